// File: rtl/edge_debounce_pkg.sv
// Shared types for the edge debounce bank: edge mode encoding, event counter width
// and the edge qualification rule used by every channel.
package edge_debounce_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2,
    EDGE_OFF  = 2'd3
  } edge_mode_t;

  localparam int EVENT_CNT_W = 8;

  // True when a transition towards new_level should produce a pulse under mode m.
  function automatic logic edge_qualifies(edge_mode_t m, logic new_level);
    case (m)
      EDGE_RISE: return new_level;
      EDGE_FALL: return !new_level;
      EDGE_BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_debounce_bank_debounce_channel.sv
// One debounce channel: synchronizer, disagreement counter, debounced level, edge pulse
// and, with EVENT_COUNT_EN defined, a saturating 8-bit pulse counter.
//
// level | meaning
// 0     | debounced low; counter runs while sync_i reads high
// 1     | debounced high; counter runs while sync_i reads low
module debounce_channel
  import edge_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   din,
  input  edge_mode_t             mode,
`ifdef EVENT_COUNT_EN
  input  logic                   count_clr,
  output logic [EVENT_CNT_W-1:0] event_count,
`endif
  output logic                   level,
  output logic                   pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_i;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   level_q;
  logic                   level_d;
  logic                   pulse_q;
  logic                   pulse_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_i = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Any agreeing sample restarts the count, so only an unbroken run can flip the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync_i != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_i;
        pulse_d = edge_qualifies(mode, sync_i);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

`ifdef EVENT_COUNT_EN
  logic [EVENT_CNT_W-1:0] event_q;

  always_ff @(posedge clk) begin
    if (reset || count_clr) begin
      event_q <= '0;
    end else if (pulse_q && (event_q != {EVENT_CNT_W{1'b1}})) begin
      event_q <= event_q + EVENT_CNT_W'(1);
    end
  end

  assign event_count = event_q;
`endif

endmodule

// File: rtl/edge_debounce_bank.sv
// Bank of independent debounced edge detectors sharing one edge mode.
// Define EVENT_COUNT_EN to add count_clr/event_count per-channel pulse counters.
module edge_debounce_bank
  import edge_debounce_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             din,
  input  logic [1:0]                      mode,
`ifdef EVENT_COUNT_EN
  input  logic                            count_clr,
  output logic [CHANNELS*EVENT_CNT_W-1:0] event_count,
`endif
  output logic [CHANNELS-1:0]             level,
  output logic [CHANNELS-1:0]             pulse
);

  edge_mode_t mode_e;

  assign mode_e = edge_mode_t'(mode);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .din         (din[i]),
      .mode        (mode_e),
`ifdef EVENT_COUNT_EN
      .count_clr   (count_clr),
      .event_count (event_count[EVENT_CNT_W*i +: EVENT_CNT_W]),
`endif
      .level       (level[i]),
      .pulse       (pulse[i])
    );
  end

endmodule

// File: tb/tb_edge_debounce_bank.sv
// Self-checking bench for edge_debounce_bank: directed scenarios plus random stimulus,
// compared every cycle against a run-length behavioural model.
module tb_edge_debounce_bank;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] din = '0;
  logic [1:0]    mode = 2'd0;
  logic          count_clr = 1'b0;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
`ifdef EVENT_COUNT_EN
  logic [CH*8-1:0] event_count;
`endif

  edge_debounce_bank #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .mode        (mode),
`ifdef EVENT_COUNT_EN
    .count_clr   (count_clr),
    .event_count (event_count),
`endif
    .level       (level),
    .pulse       (pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: din history (delay line of the synchronizer), run length of disagreement,
  // accepted level, pulse of the last edge, saturating pulse counts.
  int m_hist [CH][SS];
  int m_run  [CH];
  int m_lvl  [CH];
  int m_pul  [CH];
  int m_cnt  [CH];
  int pcnt   [CH];

  logic [CH-1:0]   mlev;
  logic [CH-1:0]   mpul;
  logic [CH*8-1:0] mcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Applies the rules for one clock edge using the inputs that were present at it.
  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      if (reset) begin
        for (int k = 0; k < SS; k++) m_hist[c][k] = 0;
        m_run[c] = 0;
        m_lvl[c] = 0;
        m_pul[c] = 0;
        m_cnt[c] = 0;
      end else begin
        int s;
        int new_pul;
        s = m_hist[c][SS-1];
        new_pul = 0;
        if (s != m_lvl[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == DC) begin
            m_lvl[c] = s;
            m_run[c] = 0;
            new_pul = (mode == 2'd2) || (mode == 2'd0 && s == 1) || (mode == 2'd1 && s == 0);
          end
        end else begin
          m_run[c] = 0;
        end
        if (count_clr) m_cnt[c] = 0;
        else if (m_pul[c] == 1 && m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
        m_pul[c] = new_pul;
        for (int k = SS - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = din[c] ? 1 : 0;
      end
      mlev[c] = (m_lvl[c] != 0);
      mpul[c] = (m_pul[c] != 0);
      mcnt[8*c +: 8] = 8'(m_cnt[c]);
    end
  endtask

  // One clock: wait for the falling edge, advance the model, compare all outputs.
  task automatic cycle();
    @(negedge clk);
    model_step();
    chk("level", 32'(level), 32'(mlev));
    chk("pulse", 32'(pulse), 32'(mpul));
`ifdef EVENT_COUNT_EN
    chk("event_count", 32'(event_count), 32'(mcnt));
`endif
    for (int c = 0; c < CH; c++) pcnt[c] += pulse[c] ? 1 : 0;
  endtask

  task automatic clr_pcnt();
    for (int c = 0; c < CH; c++) pcnt[c] = 0;
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < SS; k++) m_hist[c][k] = 0;
      m_run[c] = 0; m_lvl[c] = 0; m_pul[c] = 0; m_cnt[c] = 0; pcnt[c] = 0;
    end
    mlev = '0; mpul = '0; mcnt = '0;

    // Reset with all inputs high, then full-latency acceptance.
    reset = 1'b1; din = 4'hF; mode = 2'd0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_pulse", 32'(pulse), 32'h0);
`ifdef EVENT_COUNT_EN
      chk("rst_count", 32'(event_count), 32'h0);
`endif
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 5) chk("lat_level_e5", 32'(level), 32'h0);
      if (k == 6) chk("lat_level_e6", 32'(level), 32'hF);
    end
    din = 4'h0;
    for (int k = 0; k < 10; k++) cycle();

    // Single rise on channel 0, mode rise.
    clr_pcnt();
    din[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 5) chk("ch0_level_e5", 32'(level), 32'h0);
      if (k == 6) chk("ch0_level_e6", 32'(level), 32'h1);
      if (k == 6) chk("ch0_pulse_e6", 32'(pulse), 32'h1);
      if (k == 7) chk("ch0_pulse_e7", 32'(pulse), 32'h0);
    end
    chk("ch0_pulse_count", 32'(pcnt[0]), 32'd1);
    chk("other_pulse_count", 32'(pcnt[1] + pcnt[2] + pcnt[3]), 32'd0);
    din[0] = 1'b0;
    for (int k = 0; k < 10; k++) cycle();

    // Glitch shorter than the debounce window on channel 1.
    clr_pcnt();
    din[1] = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    din[1] = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    chk("glitch_level", 32'(level), 32'h0);
    chk("glitch_pulse_count", 32'(pcnt[1]), 32'd0);

    // Both-edge mode, then fall-only mode, on channel 2.
    mode = 2'd2; clr_pcnt();
    din[2] = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    din[2] = 1'b0;
    for (int k = 0; k < 12; k++) cycle();
    chk("both_pulse_count", 32'(pcnt[2]), 32'd2);
    mode = 2'd1; clr_pcnt();
    din[2] = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    din[2] = 1'b0;
    for (int k = 0; k < 12; k++) cycle();
    chk("fall_pulse_count", 32'(pcnt[2]), 32'd1);

    // Reset in the middle of a debounce on channel 0.
    mode = 2'd0;
    din[0] = 1'b1;
    for (int k = 0; k < 2; k++) cycle();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("midrst_pulse", 32'(pulse), 32'h0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 5) chk("midrst_level_e5", 32'(level[0]), 32'h0);
      if (k == 6) chk("midrst_level_e6", 32'(level[0]), 32'h1);
      if (k == 6) chk("midrst_pulse_e6", 32'(pulse), 32'h1);
    end
    din[0] = 1'b0;
    for (int k = 0; k < 10; k++) cycle();

`ifdef EVENT_COUNT_EN
    // Saturation on channel 3, then clear coinciding with a pulse.
    begin
      bit seen;
      mode = 2'd2;
      for (int t = 0; t < 300; t++) begin
        din[3] = ~din[3];
        for (int k = 0; k < 5; k++) cycle();
      end
      for (int k = 0; k < 8; k++) cycle();
      chk("sat_count", 32'(event_count[31:24]), 32'd255);
      din[3] = ~din[3];
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        cycle();
        if (pulse[3]) seen = 1'b1;
      end
      chk("clr_pulse_seen", 32'(seen), 32'd1);
      count_clr = 1'b1;
      cycle();
      count_clr = 1'b0;
      chk("clr_wins", 32'(event_count[31:24]), 32'd0);
      for (int k = 0; k < 5; k++) cycle();
    end
`endif

    // Random bursts, mode changes, occasional reset and clear.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(5, 0) == 0) din[c] = ~din[c];
      if ($urandom_range(39, 0) == 0) mode = 2'($urandom_range(3, 0));
      if (reset) reset = ($urandom_range(2, 0) != 0);
      else reset = ($urandom_range(299, 0) == 0);
      count_clr = ($urandom_range(99, 0) == 0);
      cycle();
    end
    reset = 1'b0;
    count_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_debounce_bank.md
EDGE_DEBOUNCE_BANK -- requirements
Module: edge_debounce_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth per channel (2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive disagreeing cycles needed to accept a new level (1..65535).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on posedge clk.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port din, input, CHANNELS bits: raw, asynchronous channel inputs.
REQ-007 SHALL have port mode, input, 2 bits: global edge mode (0 rise, 1 fall, 2 both, 3 pulses disabled).
REQ-008 SHALL have port level, output, CHANNELS bits: debounced level per channel.
REQ-009 SHALL have port pulse, output, CHANNELS bits: one-cycle edge pulse per channel.
REQ-010 SHALL have, only under EVENT_COUNT_EN, ports count_clr (input, 1 bit) and event_count (output, CHANNELS*8 bits, channel i at bits [8i+7:8i]).

Function
REQ-011 Each channel SHALL pass din[i] through SYNC_STAGES flops; only the last stage (sync_i) feeds later logic.
REQ-012 Each channel SHALL hold a counter of width clog2(DEBOUNCE_CYCLES+1), cleared on any cycle where sync_i equals level[i].
REQ-013 When sync_i differs from level[i] and counter equals DEBOUNCE_CYCLES-1, level[i] SHALL take sync_i and the counter SHALL clear on that edge; otherwise the counter increments.
REQ-014 A din step stable from before edge 1 SHALL change level on edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 6 at defaults); shorter disturbances SHALL produce no level change.
REQ-015 pulse[i] SHALL be registered and SHALL be high for exactly the one cycle following the edge where level[i] changes, qualified by mode sampled at that edge: rise needs 0->1, fall needs 1->0, both accepts either, mode 3 never pulses.
REQ-016 Mode changes SHALL affect only transitions accepted after the change and SHALL never generate a pulse by themselves.
REQ-017 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each pulse in the same cycle.

Reset
REQ-018 While reset is high at a clock edge, synchronizer flops, counters, level, pulse (and event_count if present) SHALL be cleared to 0.
REQ-019 Reset mid-debounce SHALL discard partial counts; a level held high through reset SHALL be re-accepted with full latency (REQ-014) and a rise pulse.

Configuration
REQ-020 Macro EVENT_COUNT_EN defined: each channel SHALL keep an 8-bit counter incremented on every pulse[i] cycle, saturating at 255.
REQ-021 count_clr high at an edge SHALL zero all counters; clear SHALL win over a simultaneous increment.
REQ-022 Macro EVENT_COUNT_EN undefined: count_clr, event_count and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-023 Package edge_debounce_pkg SHALL hold the edge_mode_t enum (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF) and the counter width constant (8).
REQ-024 One sub-module debounce_channel (synchronizer, debounce counter, level, pulse, optional event counter) SHALL be instantiated CHANNELS times via generate.

Verification (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-025 Reset 3 cycles with din=4'hF -> level=0, pulse=0, event_count=0 throughout; level=4'hF on the 6th edge after release.
REQ-026 mode=0, din[0] 0->1 held -> level[0]=1 on edge 6; pulse[0]=1 for exactly one cycle; no other pulse bits.
REQ-027 din[1] high for 3 cycles then low -> level[1] and pulse[1] stay 0.
REQ-028 mode=2, din[2] high 12 cycles then low -> exactly two pulse[2] cycles; mode=1 repeats -> only the fall pulse.
REQ-029 EVENT_COUNT_EN, 300 accepted edges on ch3 in mode 2 -> event_count[31:24]=255; count_clr with a coincident pulse -> 0.
REQ-030 reset asserted 2 cycles into a debounce of din[0]=1 -> no pulse during reset; level[0] rises on edge 6 after release.
